// File: rtl/ram_programmer.sv
// SAP-1 RAM loader: streams valid/ready bytes into RAM addresses 0..len-1.
// Optional RAM_PROG_CHECKSUM_EN adds a running mod-2**DATA_W byte sum.
module ram_programmer #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              CLK,
   input  logic              CLR,
   input  logic              start,
   input  logic [ADDR_W:0]   load_len,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   output logic              prog_mode,
   output logic              done
`ifdef RAM_PROG_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0] checksum
`endif
);

   localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);

   typedef enum logic [1:0] {
      IDLE,
      ACCEPT,
      WRITE,
      DONE
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W:0]   count;
   logic [ADDR_W:0]   len;
   logic [ADDR_W:0]   count_nx;
   logic [ADDR_W:0]   len_clamped;

   assign count_nx = count + (ADDR_W+1)'(1);

   // A zero or oversized length means a full image, so addr never wraps.
   assign len_clamped = (load_len == '0 || load_len > DEPTH) ?
                        DEPTH : load_len;

   always_ff @(posedge CLK) begin
      if (!CLR) begin
         state     <= IDLE;
         addr      <= '0;
         count     <= '0;
         len       <= '0;
         in_ready  <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_data  <= '0;
         prog_mode <= 1'b0;
         done      <= 1'b0;
`ifdef RAM_PROG_CHECKSUM_EN
         checksum  <= '0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  len       <= len_clamped;
                  addr      <= '0;
                  count     <= '0;
                  done      <= 1'b0;
                  prog_mode <= 1'b1;
                  in_ready  <= 1'b1;
                  state     <= ACCEPT;
`ifdef RAM_PROG_CHECKSUM_EN
                  checksum  <= '0;
`endif
               end
            end
            ACCEPT: begin
               if (in_valid && in_ready) begin
                  ram_data <= in_data;
                  ram_addr <= addr;
                  ram_we   <= 1'b1;
                  in_ready <= 1'b0;
                  state    <= WRITE;
               end
            end
            WRITE: begin
               ram_we <= 1'b0;
               addr   <= addr + ADDR_W'(1);
               count  <= count_nx;
`ifdef RAM_PROG_CHECKSUM_EN
               checksum <= checksum + ram_data;
`endif
               if (count_nx == len) begin
                  state     <= DONE;
                  prog_mode <= 1'b0;
                  done      <= 1'b1;
               end else begin
                  state    <= ACCEPT;
                  in_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_programmer.sv
// Directed bench for ram_programmer with a behavioural 16x8 RAM and PC mux.
// Covers reset, full/short/stalled loads, ignored start, abort and handoff.
module tb_ram_programmer;

   logic       CLK = 1'b0;
   logic       CLR;
   logic       start;
   logic [4:0] load_len;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       ram_we;
   logic [3:0] ram_addr;
   logic [7:0] ram_data;
   logic       prog_mode;
   logic       done;
`ifdef RAM_PROG_CHECKSUM_EN
   logic [7:0] checksum;
`endif

   int n_assert = 0;
   int n_fail = 0;

   logic [7:0] mem [16];
   logic [7:0] exp_img [16];
   logic [3:0] wlog [64];
   int         wr_cnt = 0;
   int         cyc = 0;
   logic       prev_we = 1'b0;
   logic       we_long = 1'b0;
   logic [3:0] pc;
   logic [7:0] ram_out;

   always #5 CLK = ~CLK;

   ram_programmer dut (
      .CLK(CLK),
      .CLR(CLR),
      .start(start),
      .load_len(load_len),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_ready(in_ready),
      .ram_we(ram_we),
      .ram_addr(ram_addr),
      .ram_data(ram_data),
      .prog_mode(prog_mode),
      .done(done)
`ifdef RAM_PROG_CHECKSUM_EN
      ,
      .checksum(checksum)
`endif
   );

   // Behavioural SAP-1 RAM with the programmer/PC address mux.
   always @(posedge CLK) begin
      cyc <= cyc + 1;
      prev_we <= ram_we;
      if (ram_we && prev_we) we_long <= 1'b1;
      if (ram_we) begin
         mem[ram_addr] <= ram_data;
         wlog[wr_cnt[5:0]] <= ram_addr;
         wr_cnt <= wr_cnt + 1;
      end
   end

   assign ram_out = mem[prog_mode ? ram_addr : pc];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_start(input logic [4:0] len);
      start = 1'b1;
      load_len = len;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      bit ok = 1'b0;
      bit rdy;
      if (gap > 0) begin
         in_valid = 1'b0;
         repeat (gap) @(posedge CLK);
         #1;
      end
      in_valid = 1'b1;
      in_data = b;
      for (int n = 0; n < 40; n++) begin
         rdy = in_ready;
         tick();
         if (rdy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   int base;
   int c0;

   initial begin
      CLR = 1'b0;
      start = 1'b0;
      load_len = '0;
      in_valid = 1'b0;
      in_data = '0;
      pc = '0;

      // reset
      tick();
      tick();
      CLR = 1'b1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_data", ram_data, 0);
      chk("rst_prog_mode", prog_mode, 0);
      chk("rst_done", done, 0);
      tick();
      chk("idle_in_ready", in_ready, 0);

      // full load, load_len=0 means 16, in_valid held high
      base = wr_cnt;
      do_start(5'd0);
      c0 = cyc;
      chk("full_first_ready", in_ready, 1);
      chk("full_prog_mode", prog_mode, 1);
      for (int i = 0; i < 16; i++) begin
         send(8'(i), 0);
         chk("full_we", ram_we, 1);
         chk("full_addr", ram_addr, 32'(i));
      end
      in_valid = 1'b0;
      chk("full_not_done_yet", done, 0);
      tick();
      chk("full_done", done, 1);
      chk("full_cycles", 32'(cyc - c0), 32);
      chk("full_prog_off", prog_mode, 0);
      chk("full_writes", 32'(wr_cnt - base), 16);
      chk("full_we_pulse", we_long, 0);
      for (int i = 0; i < 16; i++) begin
         chk("full_wlog", wlog[(base + i) % 64], 32'(i));
         chk("full_mem", mem[i], 32'(i));
      end
`ifdef RAM_PROG_CHECKSUM_EN
      chk("full_checksum", checksum, 32'h78);
`endif

      // short load with stalls
      base = wr_cnt;
      do_start(5'd3);
      chk("short_done_clr", done, 0);
      send(8'h56, 2);
      send(8'h36, 0);
      send(8'hA5, 3);
      in_valid = 1'b0;
      chk("short_not_done", done, 0);
      tick();
      chk("short_done", done, 1);
      chk("short_writes", 32'(wr_cnt - base), 3);
      chk("short_mem0", mem[0], 32'h56);
      chk("short_mem1", mem[1], 32'h36);
      chk("short_mem2", mem[2], 32'hA5);
      chk("short_mem3", mem[3], 32'h03);
      chk("short_mem15", mem[15], 32'h0F);
`ifdef RAM_PROG_CHECKSUM_EN
      chk("short_checksum", checksum, 32'h31);
`endif

      // start mid-load is ignored
      base = wr_cnt;
      do_start(5'd5);
      send(8'h11, 0);
      send(8'h22, 1);
      start = 1'b1;
      load_len = 5'd1;
      in_valid = 1'b0;
      tick();
      start = 1'b0;
      send(8'h33, 0);
      send(8'h44, 2);
      send(8'h55, 0);
      in_valid = 1'b0;
      tick();
      chk("ign_done", done, 1);
      chk("ign_writes", 32'(wr_cnt - base), 5);
      chk("ign_mem2", mem[2], 32'h33);
      chk("ign_mem4", mem[4], 32'h55);
      chk("ign_mem5", mem[5], 32'h05);

      // abort after 4th write
      base = wr_cnt;
      do_start(5'd16);
      send(8'hA0, 0);
      send(8'hA1, 0);
      send(8'hA2, 0);
      send(8'hA3, 0);
      in_valid = 1'b0;
      chk("abort_we_pre", ram_we, 1);
      CLR = 1'b0;
      tick();
      chk("abort_we", ram_we, 0);
      chk("abort_done", done, 0);
      chk("abort_prog", prog_mode, 0);
      chk("abort_ready", in_ready, 0);
      chk("abort_writes", 32'(wr_cnt - base), 4);
      chk("abort_mem3", mem[3], 32'hA3);
      chk("abort_mem4", mem[4], 32'h55);
      CLR = 1'b1;
      tick();
      chk("abort_idle_ready", in_ready, 0);
      base = wr_cnt;
      do_start(5'd2);
      send(8'hB0, 0);
      send(8'hB1, 1);
      in_valid = 1'b0;
      tick();
      chk("reload_done", done, 1);
      chk("reload_writes", 32'(wr_cnt - base), 2);
      chk("reload_mem0", mem[0], 32'hB0);
      chk("reload_mem1", mem[1], 32'hB1);
      chk("reload_mem2", mem[2], 32'hA2);
`ifdef RAM_PROG_CHECKSUM_EN
      chk("reload_checksum", checksum, 32'h61);
`endif

      // handoff: PC drives the RAM after done
      exp_img[0] = 8'hB0;
      exp_img[1] = 8'hB1;
      exp_img[2] = 8'hA2;
      exp_img[3] = 8'hA3;
      exp_img[4] = 8'h55;
      for (int i = 5; i < 16; i++) exp_img[i] = 8'(i);
      for (int i = 0; i < 16; i++) begin
         pc = 4'(i);
         tick();
         chk("handoff_prog", prog_mode, 0);
         chk("handoff_data", ram_out, 32'(exp_img[i]));
      end
      chk("final_we_pulse", we_long, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
